// File: rtl/huffman_frame_arbiter.sv
// -----------------------------------------------------------------------------
// huffman_frame_arbiter
//
// Shares a single huffman_encoder between two byte-stream sources. Ownership
// changes only at frame boundaries. A frame is granted round-robin and its bytes
// are forwarded to the encoder. The arbiter then waits until every code for that
// frame has returned before it arbitrates again. Because of this, every code
// coming back from the encoder belongs to the current grant. Each code is tagged
// with the owning channel, and the frame's final code is flagged.
//
// Parameters
//   MAX_OUTST  maximum bytes accepted by the encoder whose codes have not yet
//              returned (>= 1)
//   OUTST_W    width of the outstanding-byte counter; must be able to hold
//              MAX_OUTST
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   s0_data/valid/last, s0_ready  channel 0 byte stream; ready = accepted now
//   s1_data/valid/last, s1_ready  channel 1 byte stream
//   enc_enable                    encoder enable (high whenever not IDLE)
//   enc_in_enable, enc_data_in    byte offered to the encoder
//   enc_in_ready                  encoder takes the offered byte this cycle
//   enc_out_valid, enc_data_out   one-cycle code return from the encoder
//   m_data, m_valid, m_ch, m_last registered tagged code output (1-cycle pulse)
//   busy                          arbiter is not IDLE
//   err_spurious                  sticky: a code arrived with nothing pending
// -----------------------------------------------------------------------------
module huffman_frame_arbiter #(
  parameter int MAX_OUTST = 8,
  parameter int OUTST_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s0_data,
  input  logic        s0_valid,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic [7:0]  s1_data,
  input  logic        s1_valid,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic        enc_enable,
  output logic        enc_in_enable,
  output logic [7:0]  enc_data_in,
  input  logic        enc_in_ready,
  input  logic        enc_out_valid,
  input  logic [15:0] enc_data_out,
  output logic [15:0] m_data,
  output logic        m_valid,
  output logic        m_ch,
  output logic        m_last,
  output logic        busy,
  output logic        err_spurious
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_FEED  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [OUTST_W-1:0] OUTST_MAX_C  = OUTST_W'(MAX_OUTST);
  localparam logic [OUTST_W-1:0] OUTST_ONE_C  = OUTST_W'(1);
  localparam logic [OUTST_W-1:0] OUTST_ZERO_C = OUTST_W'(0);

  state_t             state_r;
  state_t             state_nxt_s;
  logic               gnt_r;
  logic               last_gnt_r;
  logic [OUTST_W-1:0] outst_r;

  logic               any_valid_s;
  logic               pick_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic [7:0]         g_data_s;
  logic               room_s;
  logic               offer_s;
  logic               accept_s;
  logic               code_ok_s;
  logic               spurious_s;
  logic               final_code_s;

  logic [15:0]        m_data_r;
  logic               m_valid_r;
  logic               m_ch_r;
  logic               m_last_r;
  logic               err_spurious_r;

  // Round-robin choice: prefer the channel that did not own the previous frame.
  always_comb begin
    any_valid_s = s0_valid | s1_valid;
    if (last_gnt_r == 1'b0) begin
      pick_s = s1_valid ? 1'b1 : 1'b0;
    end else begin
      pick_s = s0_valid ? 1'b0 : 1'b1;
    end
  end

  // Mux the granted channel's byte stream.
  always_comb begin
    if (gnt_r == 1'b1) begin
      g_valid_s = s1_valid;
      g_last_s  = s1_last;
      g_data_s  = s1_data;
    end else begin
      g_valid_s = s0_valid;
      g_last_s  = s0_last;
      g_data_s  = s0_data;
    end
  end

  // Byte handshake and code bookkeeping qualifiers.
  always_comb begin
    // Room is judged on the registered count, so a code returning in the same
    // cycle does not open a slot until the next cycle.
    room_s       = (outst_r < OUTST_MAX_C);
    offer_s      = (state_r == ST_FEED) & g_valid_s & room_s;
    accept_s     = offer_s & enc_in_ready;
    code_ok_s    = enc_out_valid & (outst_r != OUTST_ZERO_C);
    spurious_s   = enc_out_valid & (outst_r == OUTST_ZERO_C);
    // In DRAIN, no more bytes can join the frame, so the last pending code is
    // the frame's final code.
    final_code_s = code_ok_s & (state_r == ST_DRAIN) & (outst_r == OUTST_ONE_C);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_valid_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        state_nxt_s = ST_FEED;
      end
      ST_FEED: begin
        if (accept_s && g_last_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (code_ok_s && (outst_r == OUTST_ONE_C)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: encoder control and per-channel ready.
  always_comb begin
    enc_enable    = 1'b0;
    enc_in_enable = 1'b0;
    enc_data_in   = 8'h00;
    s0_ready      = 1'b0;
    s1_ready      = 1'b0;
    busy          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        enc_enable = 1'b0;
        busy       = 1'b0;
      end
      ST_GRANT: begin
        enc_enable = 1'b1;
        busy       = 1'b1;
      end
      ST_FEED: begin
        enc_enable    = 1'b1;
        busy          = 1'b1;
        enc_in_enable = offer_s;
        enc_data_in   = g_data_s;
        s0_ready      = accept_s & ~gnt_r;
        s1_ready      = accept_s & gnt_r;
      end
      ST_DRAIN: begin
        enc_enable = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        enc_enable = 1'b0;
        busy       = 1'b0;
      end
    endcase
  end

  // Grant latch: updated only when IDLE arbitration selects a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r      <= 1'b0;
      last_gnt_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && any_valid_s) begin
      gnt_r      <= pick_s;
      last_gnt_r <= pick_s;
    end else begin
      gnt_r      <= gnt_r;
      last_gnt_r <= last_gnt_r;
    end
  end

  // Outstanding-byte counter: bytes accepted by the encoder whose codes are still pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_r <= OUTST_ZERO_C;
    end else begin
      case ({accept_s, code_ok_s})
        2'b10:   outst_r <= outst_r + OUTST_ONE_C;
        2'b01:   outst_r <= outst_r - OUTST_ONE_C;
        default: outst_r <= outst_r;
      endcase
    end
  end

  // Registered code output, tagged with owner and end-of-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data_r  <= 16'h0000;
      m_valid_r <= 1'b0;
      m_ch_r    <= 1'b0;
      m_last_r  <= 1'b0;
    end else if (code_ok_s) begin
      m_data_r  <= enc_data_out;
      m_valid_r <= 1'b1;
      m_ch_r    <= gnt_r;
      m_last_r  <= final_code_s;
    end else begin
      m_data_r  <= m_data_r;
      m_valid_r <= 1'b0;
      m_ch_r    <= m_ch_r;
      m_last_r  <= 1'b0;
    end
  end

  // Sticky flag for a code that no accepted byte accounts for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_spurious_r <= 1'b0;
    end else begin
      err_spurious_r <= err_spurious_r | spurious_s;
    end
  end

  assign m_data       = m_data_r;
  assign m_valid      = m_valid_r;
  assign m_ch         = m_ch_r;
  assign m_last       = m_last_r;
  assign err_spurious = err_spurious_r;

endmodule

// File: tb/tb_huffman_frame_arbiter.sv
module tb_huffman_frame_arbiter;

  localparam int TB_MAX = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s0_data;
  logic        s0_valid;
  logic        s0_last;
  logic        s0_ready;
  logic [7:0]  s1_data;
  logic        s1_valid;
  logic        s1_last;
  logic        s1_ready;
  logic        enc_enable;
  logic        enc_in_enable;
  logic [7:0]  enc_data_in;
  logic        enc_in_ready;
  logic        enc_out_valid;
  logic [15:0] enc_data_out;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ch;
  logic        m_last;
  logic        busy;
  logic        err_spurious;

  huffman_frame_arbiter #(.MAX_OUTST(TB_MAX), .OUTST_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .enc_enable(enc_enable), .enc_in_enable(enc_in_enable), .enc_data_in(enc_data_in),
    .enc_in_ready(enc_in_ready), .enc_out_valid(enc_out_valid), .enc_data_out(enc_data_out),
    .m_data(m_data), .m_valid(m_valid), .m_ch(m_ch), .m_last(m_last),
    .busy(busy), .err_spurious(err_spurious)
  );

  typedef struct packed { logic [7:0] data; logic last; } src_t;
  typedef struct packed { logic [15:0] data; logic ch; logic last; } exp_t;
  typedef struct { logic [7:0] b; int unsigned due; } enc_t;

  src_t src0_q[$];
  src_t src1_q[$];
  exp_t exp_q[$];
  enc_t enc_q[$];

  int   tests = 0;
  int   fails = 0;
  logic flush_req, spur_req, force_stall, rnd_ready, sb_off, chk_outst;
  logic last_ch;
  int   lat_min, lat_max;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Source driver, channel 0: presents queue head and pops it on handshake.
  initial begin
    logic acc;
    s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
    forever begin
      @(negedge clk);
      acc = s0_valid & s0_ready;
      @(posedge clk); #1;
      if (flush_req) src0_q.delete();
      else if (acc && src0_q.size() > 0) void'(src0_q.pop_front());
      if (src0_q.size() > 0) begin
        s0_valid = 1'b1; s0_data = src0_q[0].data; s0_last = src0_q[0].last;
      end else begin
        s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
      end
    end
  end

  // Source driver, channel 1.
  initial begin
    logic acc;
    s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
    forever begin
      @(negedge clk);
      acc = s1_valid & s1_ready;
      @(posedge clk); #1;
      if (flush_req) src1_q.delete();
      else if (acc && src1_q.size() > 0) void'(src1_q.pop_front());
      if (src1_q.size() > 0) begin
        s1_valid = 1'b1; s1_data = src1_q[0].data; s1_last = src1_q[0].last;
      end else begin
        s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
      end
    end
  end

  // Encoder model: in-order codes {A5,byte}, latency lat_min..lat_max cycles.
  initial begin
    logic        acc;
    logic [7:0]  b;
    int unsigned cyc;
    int unsigned due;
    enc_t        e;
    cyc = 0;
    enc_out_valid = 1'b0; enc_data_out = 16'h0000; enc_in_ready = 1'b1;
    forever begin
      @(negedge clk);
      acc = enc_in_enable & enc_in_ready;
      b   = enc_data_in;
      @(posedge clk); #1;
      cyc++;
      if (flush_req) begin
        enc_q.delete();
        acc = 1'b0;
      end
      if (acc) begin
        due = cyc + 32'($urandom_range(lat_max, lat_min));
        if (enc_q.size() > 0 && due <= enc_q[$].due) due = enc_q[$].due + 1;
        e.b = b; e.due = due;
        enc_q.push_back(e);
      end
      if (enc_q.size() > 0 && enc_q[0].due <= cyc) begin
        enc_out_valid = 1'b1;
        enc_data_out  = {8'hA5, enc_q[0].b};
        void'(enc_q.pop_front());
      end else if (spur_req && enc_q.size() == 0) begin
        enc_out_valid = 1'b1;
        enc_data_out  = 16'hA5EE;
      end else begin
        enc_out_valid = 1'b0;
        enc_data_out  = 16'h0000;
      end
      if (force_stall) enc_in_ready = 1'b0;
      else if (rnd_ready) enc_in_ready = ($urandom_range(3, 0) != 0);
      else enc_in_ready = 1'b1;
    end
  end

  // Monitor: scoreboard pops on m_valid, plus per-cycle protocol checks.
  initial begin
    exp_t e;
    int   outst;
    forever begin
      @(negedge clk);
      if (rst_n && !flush_req) begin
        if (m_valid && !sb_off) begin
          if (exp_q.size() == 0) begin
            check("unexpected_m_valid", 32'(m_data), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("m_data", 32'(m_data), 32'(e.data));
            check("m_ch", 32'(m_ch), 32'(e.ch));
            check("m_last", 32'(m_last), 32'(e.last));
          end
        end
        if (!enc_in_ready) check("ready_in_stall", 32'({s0_ready, s1_ready}), 32'd0);
        if (chk_outst) begin
          outst = enc_q.size() + (enc_out_valid ? 1 : 0);
          check("outst_bound", 32'(outst <= TB_MAX), 32'd1);
          if (outst == TB_MAX) check("in_enable_full", 32'(enc_in_enable), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_m_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_m_ch"}, 32'(m_ch), 32'd0);
    check({tag, "_m_last"}, 32'(m_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err"}, 32'(err_spurious), 32'd0);
    check({tag, "_enc_enable"}, 32'(enc_enable), 32'd0);
    check({tag, "_enc_in_enable"}, 32'(enc_in_enable), 32'd0);
    check({tag, "_enc_data_in"}, 32'(enc_data_in), 32'd0);
    check({tag, "_s_ready"}, 32'({s0_ready, s1_ready}), 32'd0);
  endtask

  // Reference model: random frames per channel, expected codes in round-robin frame order.
  task automatic run_batch(input int n0, input int n1, input int lmin, input int lmax);
    logic [7:0] b0[$];
    logic [7:0] b1[$];
    int l0[$];
    int l1[$];
    int k0, k1, p0, p1, len, ch;
    exp_t e;
    src_t s;
    k0 = 0; k1 = 0; p0 = 0; p1 = 0;
    for (int f = 0; f < n0; f++) begin
      len = $urandom_range(lmax, lmin);
      l0.push_back(len);
      for (int j = 0; j < len; j++) b0.push_back(8'($urandom));
    end
    for (int f = 0; f < n1; f++) begin
      len = $urandom_range(lmax, lmin);
      l1.push_back(len);
      for (int j = 0; j < len; j++) b1.push_back(8'($urandom));
    end
    while (k0 < n0 || k1 < n1) begin
      if (last_ch == 1'b0) ch = (k1 < n1) ? 1 : 0;
      else ch = (k0 < n0) ? 0 : 1;
      if (ch == 0) begin
        for (int j = 0; j < l0[k0]; j++) begin
          e.data = {8'hA5, b0[p0]}; e.ch = 1'b0; e.last = (j == l0[k0] - 1);
          exp_q.push_back(e); p0++;
        end
        k0++;
        last_ch = 1'b0;
      end else begin
        for (int j = 0; j < l1[k1]; j++) begin
          e.data = {8'hA5, b1[p1]}; e.ch = 1'b1; e.last = (j == l1[k1] - 1);
          exp_q.push_back(e); p1++;
        end
        k1++;
        last_ch = 1'b1;
      end
    end
    p0 = 0;
    for (int f = 0; f < n0; f++)
      for (int j = 0; j < l0[f]; j++) begin
        s.data = b0[p0]; s.last = (j == l0[f] - 1); src0_q.push_back(s); p0++;
      end
    p1 = 0;
    for (int f = 0; f < n1; f++)
      for (int j = 0; j < l1[f]; j++) begin
        s.data = b1[p1]; s.last = (j == l1[f] - 1); src1_q.push_back(s); p1++;
      end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0 || enc_q.size() > 0 ||
            busy || exp_q.size() > 0) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drained"}, 32'(n < 4000), 32'd1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic wait_src0_le(input int n, input string tag);
    int c;
    c = 0;
    while (src0_q.size() > n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_progress"}, 32'(c < 2000), 32'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    exp_t e;
    src_t s;
    rst_n = 1'b0; flush_req = 1'b0; spur_req = 1'b0; force_stall = 1'b0;
    rnd_ready = 1'b0; sb_off = 1'b0; chk_outst = 1'b1; last_ch = 1'b1;
    lat_min = 3; lat_max = 3;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Directed ch0 frame 05,44,32 with fixed 3-cycle latency.
    e.ch = 1'b0; e.last = 1'b0;
    e.data = 16'hA505; exp_q.push_back(e);
    e.data = 16'hA544; exp_q.push_back(e);
    e.data = 16'hA532; e.last = 1'b1; exp_q.push_back(e);
    s.last = 1'b0;
    s.data = 8'h05; src0_q.push_back(s);
    s.data = 8'h44; src0_q.push_back(s);
    s.data = 8'h32; s.last = 1'b1; src0_q.push_back(s);
    last_ch = 1'b0;
    wait_done("directed");

    // Both channels, two 2-byte frames each: strict alternation.
    run_batch(2, 2, 2, 2);
    wait_done("alternate");

    // Encoder stalls for 5 cycles in the middle of a ch0 frame.
    run_batch(1, 0, 6, 6);
    wait_src0_le(3, "stall");
    force_stall = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    force_stall = 1'b0;
    wait_done("stall");

    // Long latency keeps the outstanding window full.
    lat_min = 10; lat_max = 10;
    run_batch(2, 2, 3, 6);
    wait_done("latency10");

    // Randomised latency, ready and frame mix.
    rnd_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      lat_min = 1; lat_max = $urandom_range(6, 1);
      run_batch($urandom_range(3, 0), $urandom_range(3, 0), 1, 5);
      wait_done("random");
    end
    rnd_ready = 1'b0;
    lat_min = 3; lat_max = 3;
    check("err_before_spurious", 32'(err_spurious), 32'd0);

    // Spurious code while IDLE: dropped and flagged.
    chk_outst = 1'b0;
    spur_req = 1'b1;
    @(posedge clk); #2;
    spur_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("err_spurious_set", 32'(err_spurious), 32'd1);
    chk_outst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("err_spurious_sticky", 32'(err_spurious), 32'd1);
    check("idle_after_spurious", 32'(busy), 32'd0);

    // Reset in the middle of a ch0 frame; the partial frame is discarded.
    sb_off = 1'b1;
    s.last = 1'b0;
    for (int j = 0; j < 12; j++) begin
      s.data = 8'($urandom); s.last = (j == 11); src0_q.push_back(s);
    end
    wait_src0_le(8, "midfeed");
    check("midfeed_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    flush_req = 1'b1;
    #1;
    check_all_zero("rst_mid");
    repeat (3) @(posedge clk);
    #2;
    exp_q.delete();
    flush_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_off = 1'b0;
    last_ch = 1'b1;
    @(posedge clk); #2;
    run_batch(1, 1, 2, 3);
    wait_done("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
